axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter_if.sv | 78 +++++++
 rtl/axi_lite_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter_if
//   Bundles the requester-side command/response signals and the AXI4-Lite
//   master port of axi_lite_arbiter.
//
//   Requester side (two requesters, index i packed in each vector):
//     req_valid[1:0]   command pending
//     req_write[1:0]   1 = write, 0 = read
//     req_addr[63:0]   requester i address in [32i+31:32i]
//     req_wdata[63:0]  requester i write data in [32i+31:32i]
//     req_ready[1:0]   one-cycle accept pulse
//     rsp_valid[1:0]   one-cycle completion pulse
//     rsp_rdata[31:0]  data of the last completed read
//     rsp_err          resp[1] of the last completed transaction
//   AXI4-Lite master: AW, W, B, AR, R channels (m_axi_*).
//
//   Modports:
//     master - the arbiter (drives AXI valids, requester readies/responses)
//     slave  - the environment (requesters plus AXI slave)
// ---------------------------------------------------------------------------
interface axi_lite_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter
//   Shares one AXI4-Lite master port between two requesters with a single
//   transaction outstanding. FSM: IDLE -> ADDR -> RESP -> DONE -> IDLE, so a
//   zero-wait slave gives one transaction every four cycles.
//
//   Ports:
//     clk        rising-edge clock
//     m_aresetn  asynchronous active-low reset
//     bus        axi_lite_arbiter_if.master (requester side + AXI master)
//
//   Arbitration: round-robin between the two requesters by default (after
//   reset requester 0 wins first). Defining AXI_ARB_FIXED_PRIORITY_EN makes
//   requester 0 always win and removes the last-grant pointer.
//
//   All AXI valid/ready outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module axi_lite_arbiter (
  input  logic               clk,
  input  logic               m_aresetn,
  axi_lite_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q;
  logic        grant_q, grant_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
  logic        last_q, last_d;
`endif

  logic        grant_req;
  logic        pick;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic        unused_resp_lsb;

  // Only resp[1] (SLVERR/DECERR) is reported to requesters.
  assign unused_resp_lsb = bus.m_axi_bresp[0] ^ bus.m_axi_rresp[0];

  // armed_q holds off the first grant until one edge after reset release,
  // which also keeps req_ready low throughout reset.
  assign grant_req = armed_q && (state_q == IDLE) && (|bus.req_valid);

  always_comb begin
`ifdef AXI_ARB_FIXED_PRIORITY_EN
    pick = ~bus.req_valid[0];
`else
    if (&bus.req_valid) pick = ~last_q;
    else                pick = ~bus.req_valid[0];
`endif
  end

  // AXI handshake controls, decoded from registered state only.
  assign awvalid = (state_q == ADDR) &&  write_q && !aw_done_q;
  assign wvalid  = (state_q == ADDR) &&  write_q && !w_done_q;
  assign arvalid = (state_q == ADDR) && !write_q;
  assign bready  = (state_q == RESP) &&  write_q;
  assign rready  = (state_q == RESP) && !write_q;

  assign aw_hs = awvalid && bus.m_axi_awready;
  assign w_hs  = wvalid  && bus.m_axi_wready;
  assign ar_hs = arvalid && bus.m_axi_arready;
  assign b_hs  = bready  && bus.m_axi_bvalid;
  assign r_hs  = rready  && bus.m_axi_rvalid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
    last_d    = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_req) begin
          grant_d   = pick;
          write_d   = bus.req_write[pick];
          addr_d    = pick ? bus.req_addr[63:32]  : bus.req_addr[31:0];
          wdata_d   = pick ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifndef AXI_ARB_FIXED_PRIORITY_EN
          last_d    = pick;
`endif
          state_d   = ADDR;
        end
      end

      ADDR: begin
        if (write_q) begin
          if (aw_hs) aw_done_d = 1'b1;
          if (w_hs)  w_done_d  = 1'b1;
          // Covers AW and W completing in either order or in the same cycle.
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = RESP;
        end else if (ar_hs) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (b_hs) begin
          err_d   = bus.m_axi_bresp[1];
          state_d = DONE;
        end else if (r_hs) begin
          rdata_d = bus.m_axi_rdata;
          err_d   = bus.m_axi_rresp[1];
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      grant_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      grant_q   <= grant_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifndef AXI_ARB_FIXED_PRIORITY_EN
  // Pointer resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) last_q <= 1'b1;
    else            last_q <= last_d;
  end
`endif

  assign bus.req_ready     = grant_req ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid     = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;

  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = 4'b1111;
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_bready  = bready;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arvalid = arvalid;
  assign bus.m_axi_rready  = rready;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_arbiter
//   Table of directed transactions, a reset-during-response sequence, and
//   randomized transactions checked against a transaction-level model of the
//   arbitration and response-latching rules.
// ---------------------------------------------------------------------------
module tb_axi_lite_arbiter;

  logic clk = 1'b0;
  logic m_aresetn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_arbiter_if bus ();

  axi_lite_arbiter dut (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .bus       (bus)
  );

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  rw;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          r_dly;
    int          g_rr;
    int          g_fp;
    logic [31:0] erd;
    logic        eerr;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference state.
  int          m_last;
  logic [31:0] m_rdata;
  logic        m_err;

  function automatic void chk1(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void chk2(string nm, logic [1:0] act, logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic slave_idle();
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rdata   = 32'h0;
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_rdata = 32'h0;
    m_err   = 1'b0;
  endtask

  // Arbitration and response rules at transaction level.
  task automatic model_txn(input txn_t t, output int eg, output logic [31:0] erd, output logic eerr);
`ifdef AXI_ARB_FIXED_PRIORITY_EN
    eg = t.rv[0] ? 0 : 1;
`else
    if (t.rv == 2'b11) eg = (m_last == 0) ? 1 : 0;
    else               eg = t.rv[0] ? 0 : 1;
`endif
    m_last = eg;
    if (!t.rw[eg]) m_rdata = t.rdata;
    m_err = t.resp[1];
    erd   = m_rdata;
    eerr  = m_err;
  endtask

  // Runs one transaction starting in an IDLE cycle. Requests stay asserted
  // during service while address/data/direction are scrambled, so any
  // re-sampling shows up as wrong AXI traffic.
  task automatic do_txn(input txn_t t, input int eg, input logic [31:0] erd, input logic eerr);
    logic [31:0] ea, ed;
    logic        ew;
    logic [1:0]  oh;
    int          n;
    ea = (eg != 0) ? t.a1 : t.a0;
    ed = (eg != 0) ? t.d1 : t.d0;
    ew = t.rw[eg];
    oh = (eg != 0) ? 2'b10 : 2'b01;

    @(negedge clk);
    bus.req_valid = t.rv;
    bus.req_write = t.rw;
    bus.req_addr  = {t.a1, t.a0};
    bus.req_wdata = {t.d1, t.d0};
    slave_idle();
    #1;
    chk2("rsp_valid_idle", bus.rsp_valid, 2'b00);
    chk2("grant", bus.req_ready, oh);

    n = ew ? ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) : t.ar_dly;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.req_addr  = ~bus.req_addr;
        bus.req_wdata = {$urandom, $urandom};
        bus.req_write = ~bus.req_write;
      end
      bus.m_axi_awready = ew && (k == t.aw_dly);
      bus.m_axi_wready  = ew && (k == t.w_dly);
      bus.m_axi_arready = !ew && (k == t.ar_dly);
      #1;
      chk2("req_ready_busy", bus.req_ready, 2'b00);
      chk1("bready_addr", bus.m_axi_bready, 1'b0);
      chk1("rready_addr", bus.m_axi_rready, 1'b0);
      if (ew) begin
        chk1("awvalid", bus.m_axi_awvalid, k <= t.aw_dly);
        chk1("wvalid", bus.m_axi_wvalid, k <= t.w_dly);
        chk1("arvalid_wr", bus.m_axi_arvalid, 1'b0);
        chk32("awaddr", bus.m_axi_awaddr, ea);
        chk32("wdata", bus.m_axi_wdata, ed);
        chk32("wstrb", {28'h0, bus.m_axi_wstrb}, 32'hF);
      end else begin
        chk1("arvalid", bus.m_axi_arvalid, 1'b1);
        chk1("awvalid_rd", bus.m_axi_awvalid, 1'b0);
        chk1("wvalid_rd", bus.m_axi_wvalid, 1'b0);
        chk32("araddr", bus.m_axi_araddr, ea);
      end
    end

    for (int k = 0; k <= t.r_dly; k++) begin
      @(negedge clk);
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_bvalid  = ew && (k == t.r_dly);
      bus.m_axi_rvalid  = !ew && (k == t.r_dly);
      bus.m_axi_bresp   = t.resp;
      bus.m_axi_rresp   = t.resp;
      bus.m_axi_rdata   = t.rdata;
      #1;
      chk1("bready", bus.m_axi_bready, ew);
      chk1("rready", bus.m_axi_rready, !ew);
      chk1("awvalid_resp", bus.m_axi_awvalid, 1'b0);
      chk1("wvalid_resp", bus.m_axi_wvalid, 1'b0);
      chk1("arvalid_resp", bus.m_axi_arvalid, 1'b0);
      chk2("rsp_valid_resp", bus.rsp_valid, 2'b00);
    end

    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = $urandom;
    #1;
    chk2("rsp_valid", bus.rsp_valid, oh);
    chk32("rsp_rdata", bus.rsp_rdata, erd);
    chk1("rsp_err", bus.rsp_err, eerr);
    chk1("bready_done", bus.m_axi_bready, 1'b0);
    chk1("rready_done", bus.m_axi_rready, 1'b0);
  endtask

  task automatic chk_all_quiet(string tag);
    chk2({tag, "_req_ready"}, bus.req_ready, 2'b00);
    chk2({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    chk1({tag, "_awvalid"}, bus.m_axi_awvalid, 1'b0);
    chk1({tag, "_wvalid"}, bus.m_axi_wvalid, 1'b0);
    chk1({tag, "_arvalid"}, bus.m_axi_arvalid, 1'b0);
    chk1({tag, "_bready"}, bus.m_axi_bready, 1'b0);
    chk1({tag, "_rready"}, bus.m_axi_rready, 1'b0);
    chk32({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk1({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    chk32({tag, "_awaddr"}, bus.m_axi_awaddr, 32'h0);
    chk32({tag, "_araddr"}, bus.m_axi_araddr, 32'h0);
    chk32({tag, "_wdata"}, bus.m_axi_wdata, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t        tbl[8];
    txn_t        t;
    int          eg;
    logic [31:0] erd;
    logic        eerr;

    //            rv     rw     a0            a1            d0            d1            rdata         resp  aw w ar r rr fp erd           eerr
    tbl[0] = '{2'b01, 2'b00, 32'h4060_0008, 32'h5000_0000, 32'h0,        32'h0,        32'h0000_0001, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0000_0001, 1'b0};
    tbl[1] = '{2'b10, 2'b10, 32'h4000_0100, 32'h4060_0004, 32'h0,        32'h41,       32'hAAAA_5555, 2'b00, 2, 0, 0, 0, 1, 1, 32'h0000_0001, 1'b0};
    tbl[2] = '{2'b11, 2'b11, 32'h4000_0200, 32'h5000_0200, 32'h1111_0000, 32'h2222_0000, 32'h0,       2'b00, 0, 0, 0, 1, 0, 0, 32'h0000_0001, 1'b0};
    tbl[3] = '{2'b11, 2'b00, 32'h4000_0300, 32'h5000_0300, 32'h0,        32'h0,        32'hDEAD_BEEF, 2'b00, 0, 0, 10, 0, 1, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{2'b11, 2'b00, 32'h4000_0400, 32'h5000_0400, 32'h0,        32'h0,        32'h1234_5678, 2'b10, 0, 0, 1, 3, 0, 0, 32'h1234_5678, 1'b1};
    tbl[5] = '{2'b11, 2'b11, 32'h4000_0500, 32'h5000_0500, 32'h3333_0000, 32'h4444_0000, 32'h0,       2'b10, 1, 1, 0, 2, 1, 0, 32'h1234_5678, 1'b1};
    tbl[6] = '{2'b01, 2'b01, 32'h4000_0600, 32'h5000_0600, 32'h5555_0000, 32'h0,       32'h0,        2'b00, 3, 0, 0, 0, 0, 0, 32'h1234_5678, 1'b0};
    tbl[7] = '{2'b10, 2'b00, 32'h4000_0700, 32'h5000_0700, 32'h0,        32'h0,        32'hCAFE_0001, 2'b01, 0, 0, 0, 1, 1, 1, 32'hCAFE_0001, 1'b0};

    // Reset with requests already pending: nothing may be granted.
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h5555_0000, 32'h4444_0000};
    bus.req_wdata = 64'h0;
    slave_idle();
    repeat (3) @(negedge clk);
    #1;
    chk_all_quiet("reset");
    chk32("reset_wstrb", {28'h0, bus.m_axi_wstrb}, 32'hF);
    @(negedge clk);
    m_aresetn     = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);

    foreach (tbl[i]) begin
`ifdef AXI_ARB_FIXED_PRIORITY_EN
      eg = tbl[i].g_fp;
`else
      eg = tbl[i].g_rr;
`endif
      do_txn(tbl[i], eg, tbl[i].erd, tbl[i].eerr);
    end

    // Reset while waiting for the write response.
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr  = {32'h4060_0010, 32'h0};
    bus.req_wdata = {32'h0000_0055, 32'h0};
    slave_idle();
    #1;
    chk2("rst_seq_grant", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    #1;
    chk1("rst_seq_awvalid", bus.m_axi_awvalid, 1'b1);
    @(negedge clk);
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    #1;
    chk1("rst_seq_bready", bus.m_axi_bready, 1'b1);
    #2;
    m_aresetn = 1'b0;
    #1;
    chk_all_quiet("midrst");
    @(negedge clk);
    bus.m_axi_bvalid = 1'b1;
    #1;
    chk1("midrst_bready_hold", bus.m_axi_bready, 1'b0);
    @(negedge clk);
    bus.m_axi_bvalid = 1'b0;
    m_aresetn        = 1'b1;
    bus.req_valid    = 2'b00;
    @(negedge clk);
    model_reset();

    t = '{2'b11, 2'b00, 32'h4060_0020, 32'h4060_0024, 32'h0, 32'h0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0};
    model_txn(t, eg, erd, eerr);
    do_txn(t, eg, erd, eerr);

    for (int i = 0; i < 30; i++) begin
      t.rv     = 2'($urandom_range(1, 3));
      t.rw     = 2'($urandom_range(0, 3));
      t.a0     = $urandom;
      t.a1     = $urandom;
      t.d0     = $urandom;
      t.d1     = $urandom;
      t.rdata  = $urandom;
      t.resp   = 2'($urandom_range(0, 3));
      t.aw_dly = int'($urandom_range(0, 3));
      t.w_dly  = int'($urandom_range(0, 3));
      t.ar_dly = int'($urandom_range(0, 4));
      t.r_dly  = int'($urandom_range(0, 3));
      model_txn(t, eg, erd, eerr);
      do_txn(t, eg, erd, eerr);
    end

    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk2("final_rsp_valid", bus.rsp_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
